// File: rtl/seq_mult_hs.sv
// seq_mult_hs: iterative shift-add multiplier with valid/ready handshakes.
//
// One multiplier bit is retired per clock, so a product takes WIDTH cycles
// after acceptance. signed_mode selects two's-complement or unsigned
// operands per operation. The signed mode works on magnitudes and applies
// the sign to the final result.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   in_valid     operand set presented (a, b, signed_mode)
//   in_ready     block can accept operands (IDLE only)
//   a            multiplicand, WIDTH bits
//   b            multiplier, WIDTH bits
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   out_valid    product available (DONE)
//   out_ready    downstream accepts product
//   product      2*WIDTH-bit result; meaningful only while out_valid=1
//   busy         high in BUSY or DONE
module seq_mult_hs #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    count;
  logic             neg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    result;
  logic             last_iter;

  // Operand magnitudes. The magnitude of the most negative value is
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (signed_mode) begin
      if (a[WIDTH-1]) a_mag = '0 - a;
      if (b[WIDTH-1]) b_mag = '0 - b;
    end
  end

  // One shift-add step. The multiplicand is placed by count instead of
  // being kept in a pre-shifted 2*WIDTH register.
  always_comb begin
    addend   = '0;
    if (mplier[0]) addend = {{WIDTH{1'b0}}, mcand} << count;
    acc_next = acc + addend;
    result   = neg ? ('0 - acc_next) : acc_next;
  end

  assign last_iter = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          // The final step's sum goes straight into product so out_valid
          // rises exactly WIDTH edges after acceptance.
          if (last_iter) begin
            product <= result;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY) || (state == DONE);

endmodule

// File: tb/tb_seq_mult_hs.sv
// Testbench for seq_mult_hs (WIDTH=8): a cycle-level reference model
// checked every cycle, plus directed operations with hand-computed products.
module tb_seq_mult_hs;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          signed_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] product;
  logic          busy;

  seq_mult_hs #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int tests    = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference product.
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
    longint px, py, p;
    if (s) begin
      px = longint'($signed(x));
      py = longint'($signed(y));
    end else begin
      px = longint'(x);
      py = longint'(y);
    end
    p = px * py;
    return p[PW-1:0];
  endfunction

  // Timing model: accept when ready, result appears W edges later,
  // held until out_ready is seen.
  logic          m_ready = 1'b1;
  logic          m_valid = 1'b0;
  int            m_timer = 0;
  logic [PW-1:0] m_res   = '0;
  logic [PW-1:0] m_prod  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_ready <= 1'b1;
      m_valid <= 1'b0;
      m_timer <= 0;
      m_prod  <= '0;
    end else if (m_ready) begin
      if (in_valid) begin
        m_ready <= 1'b0;
        m_timer <= W;
        m_res   <= ref_mul(a, b, signed_mode);
      end
    end else if (m_timer != 0) begin
      m_timer <= m_timer - 1;
      if (m_timer == 1) begin
        m_valid <= 1'b1;
        m_prod  <= m_res;
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
      m_ready <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_in_ready", in_ready, m_ready);
      chk("model_out_valid", out_valid, m_valid);
      chk("model_busy", busy, !m_ready);
      if (m_valid) chk("model_product", product, m_prod);
    end
  end

  // Handshake log: accept cycle numbers and delivered products.
  int            cyc = 0;
  int            acc_q[$];
  logic [PW-1:0] res_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && in_valid && in_ready) acc_q.push_back(cyc);
    if (!rst && out_valid && out_ready) res_q.push_back(product);
  end

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       input logic [PW-1:0] exp, input logic early, input int hold);
    int lat;
    @(negedge clk);
    a = x; b = y; signed_mode = s; in_valid = 1'b1; out_ready = early;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    // Scramble inputs to show operands were captured at acceptance.
    a = ~x; b = ~y; signed_mode = ~s;
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, W);
    chk("product", product, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      chk("hold_product", product, exp);
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_handshake_in_ready", in_ready, 1'b1);
    chk("post_handshake_out_valid", out_valid, 1'b0);
    out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    int guard;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_product", product, '0);
    chk_en = 1'b1;

    do_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1, 0);
    do_op(8'h80, 8'h80, 1'b1, 16'h4000, 1'b0, 0);
    do_op(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0, 0);
    do_op(8'hFD, 8'h05, 1'b0, 16'h04F1, 1'b0, 0);
    do_op(8'h00, 8'hFF, 1'b1, 16'h0000, 1'b1, 0);
    do_op(8'h7F, 8'h80, 1'b1, 16'hC080, 1'b0, 0);
    do_op(8'h80, 8'h01, 1'b1, 16'hFF80, 1'b1, 0);
    do_op(8'h0C, 8'h0D, 1'b0, 16'h009C, 1'b0, 5);

    // Reset after three iterations discards the operation.
    @(negedge clk);
    a = 8'd9; b = 8'd9; signed_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midop_reset_in_ready", in_ready, 1'b1);
    chk("midop_reset_out_valid", out_valid, 1'b0);
    chk("midop_reset_busy", busy, 1'b0);
    chk("midop_reset_product", product, '0);
    seen = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_result_after_reset", seen, 0);
    do_op(8'd7, 8'd6, 1'b0, 16'h002A, 1'b1, 0);

    // Back-to-back with in_valid held high.
    acc_q.delete();
    res_q.delete();
    @(negedge clk);
    a = 8'h00; b = 8'hC8; signed_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (acc_q.size() < 1 && guard < 4 * W) begin
      @(negedge clk);
      guard++;
    end
    a = 8'h01; b = 8'h01;
    guard = 0;
    while (acc_q.size() < 2 && guard < 4 * W) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    guard = 0;
    while (res_q.size() < 2 && guard < 4 * W) begin
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    chk("b2b_accept_count", acc_q.size(), 2);
    chk("b2b_result_count", res_q.size(), 2);
    if (acc_q.size() >= 2) chk("b2b_spacing", acc_q[1] - acc_q[0], W + 2);
    if (res_q.size() >= 2) begin
      chk("b2b_first_product", res_q[0], 16'h0000);
      chk("b2b_second_product", res_q[1], 16'h0001);
    end
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
